// File: rtl/nibble_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_adder_pkg
// Description : Shared types and constants for the nibble-serial adder.
//               - NIB_W   : width of one adder slice (one nibble)
//               - state_t : control FSM states (IDLE -> RUN -> DONE -> IDLE)
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_adder_pkg;

  // Width of the time-multiplexed adder slice.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // waiting for an operand
    RUN  = 2'd1,   // one nibble added per cycle
    DONE = 2'd2    // result presented, waiting for the consumer
  } state_t;

endpackage : nibble_adder_pkg
`default_nettype wire

// File: rtl/ripple_carry_adder_4bit.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder_4bit
// Description : Purely combinational 4-bit ripple-carry adder slice.
//   a    in  4  addend A
//   b    in  4  addend B
//   cin  in  1  carry into bit 0
//   sum  out 4  (a + b + cin) mod 16
//   cout out 1  carry out of bit 3
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // w_carry[i] is the carry into bit i; w_carry[4] leaves the slice.
  logic [4:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign sum[gi]        = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi+1]  = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = w_carry[4];

endmodule : ripple_carry_adder_4bit
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : WIDTH-bit adder built from a single 4-bit ripple-carry slice,
//               one nibble per cycle, least-significant nibble first, with a
//               registered carry between nibble steps.
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand valid
//   in_ready   out  1      operand can be accepted (IDLE and not in reset)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry into nibble 0
//   out_valid  out  1      result valid (held until out_ready)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [WIDTH-1:0]       r_a_sh;     // operand A, consumed from the bottom
  logic [WIDTH-1:0]       r_b_sh;     // operand B, consumed from the bottom
  // Collected result nibbles. Only WIDTH-4 bits are stored: the last nibble
  // comes straight from the slice into the output register.
  logic [WIDTH-NIB_W-1:0] r_res_sh;
  logic                   r_carry;    // carry between nibble steps
  logic [CNT_W-1:0]       r_cnt;      // nibble step index within RUN

  logic [WIDTH-1:0]       r_sum;
  logic                   r_cout;
  logic                   r_ovf;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                   w_accept;
  logic                   w_release;
  logic                   w_last_step;
  logic [NIB_W-1:0]       w_slice_sum;
  logic                   w_slice_cout;
  logic [WIDTH-1:0]       w_res_next;
  logic                   w_ovf_next;

  assign in_ready    = (r_state == IDLE) & ~rst;
  assign w_accept    = in_valid & in_ready;
  assign w_release   = (r_state == DONE) & out_ready;
  assign w_last_step = (r_state == RUN) & (r_cnt == C_LAST_STEP);

  // The single time-multiplexed nibble slice.
  ripple_carry_adder_4bit u_slice (
    .a    (r_a_sh[NIB_W-1:0]),
    .b    (r_b_sh[NIB_W-1:0]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // New slice nibble enters at the top; after NIB steps nibble 0 is at the
  // bottom and the full result is assembled.
  assign w_res_next = {w_slice_sum, r_res_sh};

  // On the last step the low nibble of each operand register holds the top
  // nibble of the original operand, so bit 3 is the operand sign bit.
  assign w_ovf_next = (r_a_sh[NIB_W-1] ~^ r_b_sh[NIB_W-1])
                    & (w_slice_sum[NIB_W-1] ^ r_a_sh[NIB_W-1]);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_state_nxt = RUN;
      RUN:     if (w_last_step) w_state_nxt = DONE;
      DONE:    if (w_release)   w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand feeder, carry/counter, result collector
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_res_sh <= '0;
      r_carry  <= cin;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> NIB_W;
      r_b_sh   <= r_b_sh >> NIB_W;
      r_res_sh <= w_res_next[WIDTH-1:NIB_W];
      r_carry  <= w_slice_cout;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Output registers only change when an operation completes, so they stay
  // stable for the whole DONE phase regardless of other activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last_step) begin
      r_sum  <= w_res_next;
      r_cout <= w_slice_cout;
      r_ovf  <= w_ovf_next;
    end
  end

  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule : nibble_serial_adder
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Self-checking bench for nibble_serial_adder (WIDTH=16).
//               Expected results come from a plain-arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: {ovf, cout, sum}. Unsigned sum from wide integer addition,
  // overflow from whether the signed sum leaves the signed range.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic ci);
    longint ux, uy, full, sx, sy, sres, smax, smin;
    logic   o;
    logic [63:0] fv;
    ux   = longint'(x);
    uy   = longint'(y);
    full = ux + uy + longint'(ci);
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    sres = sx + sy + longint'(ci);
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    o    = (sres > smax) || (sres < smin);
    fv   = full;
    return {o, fv[WIDTH], fv[WIDTH-1:0]};
  endfunction

  // Handshake driver: presents one operand, then waits for out_valid while
  // holding out_ready low. Returns observed result and edges-to-valid.
  task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xc, output logic [WIDTH-1:0] s,
                       output logic c, output logic o, output int lat,
                       output bit ok);
    int w;
    w   = 0;
    ok  = 1'b1;
    lat = 0;
    s   = '0;
    c   = 1'b0;
    o   = 1'b0;
    out_ready = 1'b0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      return;
    end
    in_valid = 1'b1;
    a = xa; b = xb; cin = xc;
    @(posedge clk); #1;
    // Scramble inputs: they must only be sampled on the accept edge.
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) ok = 1'b0;
    s = sum; c = cout; o = ovf;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_low got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_low2 got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_tests++;
    if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b want 0/0/0", sum, cout, ovf);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready_after got %b want 1", in_ready);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_directed_vectors();
    logic [WIDTH-1:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h00FF};
    logic [WIDTH-1:0] vb [5] = '{16'h4321, 16'h0000, 16'h0001, 16'h8000, 16'h0F01};
    logic             vc [5] = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
    logic [WIDTH-1:0] es [5] = '{16'h5555, 16'h0000, 16'h8000, 16'h0000, 16'h1001};
    logic             ec [5] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
    logic             eo [5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    logic [WIDTH-1:0] s;
    logic             c, o;
    int               lat;
    bit               ok;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vc[i], s, c, o, lat, ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL directed_handshake[%0d] got timeout want out_valid", i);
      end
      n_tests++;
      if (lat !== NIB) begin
        n_fail++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, NIB);
      end
      n_tests++;
      if (s !== es[i] || c !== ec[i] || o !== eo[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d] got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, s, c, o, es[i], ec[i], eo[i]);
      end
      drain();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_release[%0d] got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [WIDTH-1:0] s;
    logic             c, o;
    int               lat;
    bit               ok, stable;
    logic [WIDTH+1:0] exp;
    do_op(16'hA5A5, 16'h1111, 1'b1, s, c, o, lat, ok);
    exp = ref_add(16'hA5A5, 16'h1111, 1'b1);
    n_tests++;
    if (!ok || {o, c, s} !== exp) begin
      n_fail++; $display("FAIL bp_result got ok=%0d %h want %h", ok, {o, c, s}, exp);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== exp) stable = 1'b0;
    end
    in_valid = 1'b0;
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("FAIL bp_hold got out_valid=%b in_ready=%b res=%h want 1/0/%h", out_valid, in_ready, {ovf, cout, sum}, exp);
    end
    drain();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    do_op(16'h0001, 16'h0002, 1'b0, s, c, o, lat, ok);
    n_tests++;
    if (!ok || lat !== NIB || s !== 16'h0003 || c !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_op got ok=%0d lat=%0d sum=%h cout=%b want 1/%0d/0003/0", ok, lat, s, c, NIB);
    end
    drain();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_run();
    logic [WIDTH-1:0] s;
    logic             c, o;
    int               lat;
    bit               ok, quiet;
    in_valid = 1'b1;
    a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    @(posedge clk); #1;           // accept edge
    in_valid = 1'b0;
    @(posedge clk); #1;           // now in the 2nd RUN cycle
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_run_during got out_valid=%b in_ready=%b want 0/0", out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_run_idle got in_ready=%b want 1", in_ready);
    end
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++; $display("FAIL rst_run_no_result got out_valid=1 want 0");
    end
    do_op(16'h0F0F, 16'h00F1, 1'b0, s, c, o, lat, ok);
    n_tests++;
    if (!ok || s !== 16'h1000 || c !== 1'b0 || o !== 1'b0) begin
      n_fail++; $display("FAIL rst_run_follow got ok=%0d sum=%h cout=%b ovf=%b want 1/1000/0/0", ok, s, c, o);
    end
    drain();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    logic [WIDTH-1:0] s, ra, rb;
    logic             c, o, rc;
    int               lat, errs;
    bit               ok;
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
      rc = 1'($urandom);
      exp = ref_add(ra, rb, rc);
      do_op(ra, rb, rc, s, c, o, lat, ok);
      errs = 0;
      if (!ok || lat !== NIB) errs++;
      n_tests++;
      if (errs != 0 || {o, c, s} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h cin=%b got ok=%0d lat=%0d res=%h want lat=%0d res=%h",
                 i, ra, rb, rc, ok, lat, {o, c, s}, NIB, exp);
      end
      drain();
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [WIDTH+1:0] exp_q [$];
    logic [WIDTH+1:0] exp;
    int cyc, last_acc, got, sent;
    bit acc;
    cyc = 0; last_acc = -1; got = 0; sent = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    while (got < 8 && cyc < 200) begin
      acc = in_ready && in_valid;
      if (acc) begin
        exp_q.push_back(ref_add(a, b, cin));
        if (last_acc >= 0) begin
          n_tests++;
          if (cyc - last_acc != NIB + 2) begin
            n_fail++; $display("FAIL b2b_spacing got %0d want %0d", cyc - last_acc, NIB + 2);
          end
        end
        last_acc = cyc;
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        if (sent >= 8) in_valid = 1'b0;
      end
      if (out_valid) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_unexpected got result %h want none", {ovf, cout, sum});
        end else begin
          exp = exp_q.pop_front();
          if ({ovf, cout, sum} !== exp) begin
            n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", got, {ovf, cout, sum}, exp);
          end
        end
        got++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (got != 8) begin
      n_fail++; $display("FAIL b2b_count got %0d want 8", got);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    test_reset();
    test_directed_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_nibble_serial_adder
`default_nettype wire
